// File: rtl/core_issue_arbiter.sv
// Round-robin issue arbiter that feeds one single-cycle Core from two requester FIFOs.
// Issue outputs are registered. Ready and idle are decoded combinationally from FIFO state.
module core_issue_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [15:0]      req0_instr,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_instr,
  output logic             req1_ready,
  input  logic             issue_en,
  input  logic             flush,
  output logic             instr_valid,
  output logic [15:0]      instr,
  output logic             grant_id,
  output logic [CNT_W-1:0] issued0,
  output logic [CNT_W-1:0] issued1,
  output logic             idle
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [2][DEPTH];
  logic [PTR_W-1:0]  r_wr  [2];
  logic [PTR_W-1:0]  r_rd  [2];
  logic [FILL_W-1:0] r_cnt [2];

  logic              r_instr_valid;
  logic [DATA_W-1:0] r_instr;
  logic              r_grant_id;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_issued0;
  logic [CNT_W-1:0]  r_issued1;

  logic [DATA_W-1:0] w_data [2];
  logic [1:0]        w_valid;
  logic [1:0]        w_full;
  logic [1:0]        w_nonempty;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic              w_winner;
  logic [DATA_W-1:0] w_head;

  assign w_data[0] = req0_instr;
  assign w_data[1] = req1_instr;
  assign w_valid   = {req1_valid, req0_valid};

  for (genvar g = 0; g < 2; g++) begin : gen_status
    assign w_full[g]     = (r_cnt[g] == FILL_W'(DEPTH));
    assign w_nonempty[g] = (r_cnt[g] != '0);
    assign w_push[g]     = w_valid[g] && !w_full[g];
  end

  // Round-robin pick: the requester that did not win last time gets priority under contention.
  always_comb begin
    w_pop    = '0;
    w_winner = 1'b0;
    if (issue_en && !flush) begin
      if (w_nonempty[0] && (!w_nonempty[1] || r_last_grant)) begin
        w_pop[0] = 1'b1;
        w_winner = 1'b0;
      end else if (w_nonempty[1]) begin
        w_pop[1] = 1'b1;
        w_winner = 1'b1;
      end
    end
    w_head = r_mem[w_winner][r_rd[w_winner]];
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i] && !flush) begin
        r_mem[i][r_wr[i]] <= w_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush) begin
          r_wr[i]  <= '0;
          r_rd[i]  <= '0;
          r_cnt[i] <= '0;
        end else begin
          if (w_push[i]) r_wr[i] <= r_wr[i] + PTR_W'(1);
          if (w_pop[i])  r_rd[i] <= r_rd[i] + PTR_W'(1);
          r_cnt[i] <= r_cnt[i] + FILL_W'(w_push[i]) - FILL_W'(w_pop[i]);
        end
      end
    end
  end

  // Issue stage: instr and grant_id hold on idle cycles, only instr_valid drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_grant_id    <= 1'b0;
      r_last_grant  <= 1'b1;
      r_issued0     <= '0;
      r_issued1     <= '0;
    end else begin
      r_instr_valid <= |w_pop;
      if (|w_pop) begin
        r_instr      <= w_head;
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
      end
      if (w_pop[0]) r_issued0 <= r_issued0 + CNT_W'(1);
      if (w_pop[1]) r_issued1 <= r_issued1 + CNT_W'(1);
    end
  end

  assign req0_ready  = !w_full[0];
  assign req1_ready  = !w_full[1];
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign grant_id    = r_grant_id;
  assign issued0     = r_issued0;
  assign issued1     = r_issued1;
  assign idle        = !w_nonempty[0] && !w_nonempty[1] && !r_instr_valid;

endmodule

// File: tb/tb_core_issue_arbiter.sv
// Directed bench for core_issue_arbiter: issued words are checked against an expected-order queue.
module tb_core_issue_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid;
  logic [15:0] req0_instr;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_instr;
  logic        req1_ready;
  logic        issue_en;
  logic        flush;
  logic        instr_valid;
  logic [15:0] instr;
  logic        grant_id;
  logic [3:0]  issued0;
  logic [3:0]  issued1;
  logic        idle;

  int          n_pass;
  int          n_total;
  logic [16:0] exp_q [$];

  core_issue_arbiter #(.DEPTH(4), .CNT_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_instr  (req0_instr),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_instr  (req1_instr),
    .req1_ready  (req1_ready),
    .issue_en    (issue_en),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr       (instr),
    .grant_id    (grant_id),
    .issued0     (issued0),
    .issued1     (issued1),
    .idle        (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // Advance one cycle, sample at the falling edge, and score any issued word.
  task automatic tick();
    logic [16:0] e;
    @(posedge clock);
    @(negedge clock);
    if (instr_valid) begin
      n_total++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL sb_unexpected observed=%0d_%h expected=none", grant_id, instr);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_issue", 32'({grant_id, instr}), 32'(e));
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_idle",  32'(idle),        32'd1);
    chk("rst_cnt0",  32'(issued0),     32'd0);
    chk("rst_rdy0",  32'(req0_ready),  32'd1);
    reset_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; req0_valid = 1'b0; req0_instr = '0; req1_valid = 1'b0; req1_instr = '0;
    issue_en = 1'b0; flush = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", 32'(instr),       32'h0);
    chk("reset_grant", 32'(grant_id),    32'd0);
    chk("reset_cnt",   32'({issued1, issued0}), 32'h0);
    chk("reset_idle",  32'(idle),        32'd1);
    chk("reset_ready", 32'({req1_ready, req0_ready}), 32'h3);
    reset_n = 1'b1;

    // Single push, two-cycle latency
    issue_en = 1'b1; req0_valid = 1'b1; req0_instr = 16'h1123;
    exp_q.push_back({1'b0, 16'h1123});
    tick();
    chk("t1_valid_e1", 32'(instr_valid), 32'd0);
    chk("t1_idle_e1",  32'(idle),        32'd0);
    req0_valid = 1'b0;
    tick();
    chk("t1_valid_e2", 32'(instr_valid), 32'd1);
    chk("t1_grant",    32'(grant_id),    32'd0);
    chk("t1_issued0",  32'(issued0),     32'd1);
    tick();
    chk("t1_idle_e3",  32'(idle),        32'd1);

    // Contention: strict alternation starting with requester 0 after reset
    pulse_reset();
    issue_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_instr = 16'hA000 + 16'(k);
      req1_valid = 1'b1; req1_instr = 16'hB000 + 16'(k);
      tick();
    end
    chk("t2_full0", 32'({req1_ready, req0_ready}), 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 16'hA000 + 16'(k)});
      exp_q.push_back({1'b1, 16'hB000 + 16'(k)});
    end
    issue_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_valid", 32'(instr_valid), 32'd1);
    end
    issue_en = 1'b0;
    chk("t2_issued", 32'({issued1, issued0}), 32'h44);
    tick();
    chk("t2_idle", 32'(idle), 32'd1);

    // Backpressure on requester 1: fifth word held until the first pop
    for (int k = 0; k < 5; k++) exp_q.push_back({1'b1, 16'hC000 + 16'(k)});
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req1_instr = 16'hC000 + 16'(k);
      tick();
    end
    chk("t3_ready_full", 32'(req1_ready), 32'd0);
    req1_instr = 16'hC004;
    tick();
    chk("t3_ready_held", 32'(req1_ready), 32'd0);
    chk("t3_no_issue",   32'(instr_valid), 32'd0);
    issue_en = 1'b1;
    tick();
    chk("t3_ready_back", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_valid", 32'(instr_valid), 32'd1);
    end
    tick();
    chk("t3_issued1", 32'(issued1), 32'd9);
    chk("t3_idle",    32'(idle),    32'd1);

    // Stall: issue_en 1,0,1 with three queued in FIFO0
    issue_en = 1'b0;
    req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req0_instr = 16'hD000 + 16'(k);
      exp_q.push_back({1'b0, 16'hD000 + 16'(k)});
      tick();
    end
    req0_valid = 1'b0;
    issue_en = 1'b1;
    tick();
    chk("t4_v1", 32'(instr_valid), 32'd1);
    issue_en = 1'b0;
    tick();
    chk("t4_v0",    32'(instr_valid), 32'd0);
    chk("t4_hold",  32'(instr),       32'hD000);
    issue_en = 1'b1;
    tick();
    chk("t4_v1b", 32'(instr_valid), 32'd1);
    tick();
    tick();
    chk("t4_issued0", 32'(issued0), 32'd7);
    chk("t4_idle",    32'(idle),    32'd1);

    // Flush with words queued in both FIFOs and one in flight
    issue_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_instr = 16'hE000 + 16'(k);
      req1_valid = (k < 2); req1_instr = 16'hF000 + 16'(k);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_q.push_back({1'b1, 16'hF000});
    issue_en = 1'b1;
    tick();
    chk("t5_inflight", 32'(instr_valid), 32'd1);
    flush = 1'b1; req0_valid = 1'b1; req0_instr = 16'hDEAD;
    chk("t5_ready_flush", 32'(req0_ready), 32'd1);
    tick();
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_idle",  32'(idle),        32'd1);
    chk("t5_cnt",   32'({issued1, issued0}), 32'hA7);
    flush = 1'b0; req0_instr = 16'h9F01;
    exp_q.push_back({1'b0, 16'h9F01});
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t5_post_valid", 32'(instr_valid), 32'd1);
    tick();
    chk("t5_post_cnt",  32'(issued0), 32'd8);
    chk("t5_post_idle", 32'(idle),    32'd1);

    // Reset mid-operation drops queued words; then 17 issues wrap a 4-bit counter
    issue_en = 1'b0; req0_valid = 1'b1;
    req0_instr = 16'h5000; tick();
    req0_instr = 16'h5001; tick();
    req0_valid = 1'b0;
    chk("t6_busy", 32'(idle), 32'd0);
    pulse_reset();
    issue_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      req0_valid = 1'b1; req0_instr = 16'h6000 + 16'(k);
      exp_q.push_back({1'b0, 16'h6000 + 16'(k)});
      tick();
    end
    req0_valid = 1'b0;
    tick();
    tick();
    chk("t6_wrap",    32'(issued0), 32'd1);
    chk("t6_issued1", 32'(issued1), 32'd0);
    chk("t6_idle",    32'(idle),    32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_issue_arbiter.md
Name: core_issue_arbiter

Overview:
Shares the single-cycle 16-bit Core between two instruction requesters, e.g. a host loader on port 0 and a debug injector on port 1. Each requester pushes 16-bit instructions into its own FIFO through a valid/ready handshake. The arbiter pops at most one instruction per cycle using round-robin and drives the Core's instr_valid/instr through registered outputs. It also keeps per-requester issue counters and supports a synchronous flush.

Parameters:
DEPTH, 4, entries per requester FIFO; power of 2, >= 2
CNT_W, 16, width of each issue counter

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 offers an instruction
req0_instr  input  16  requester 0 instruction
req0_ready  output  1  FIFO0 not full
req1_valid  input  1  requester 1 offers an instruction
req1_instr  input  16  requester 1 instruction
req1_ready  output  1  FIFO1 not full
issue_en  input  1  enables popping and issuing; 0 = stall
flush  input  1  synchronous discard of all queued and in-flight instructions
instr_valid  output  1  to Core instr_valid, registered
instr  output  16  to Core instr, registered
grant_id  output  1  requester that owns the current instr
issued0  output  CNT_W  count of instructions issued from requester 0
issued1  output  CNT_W  count of instructions issued from requester 1
idle  output  1  both FIFOs empty and instr_valid = 0

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clock.
- Reset values: both FIFOs empty, with read/write pointers = 0. instr_valid = 0, instr = 16'h0000, grant_id = 0, issued0 = issued1 = 0, idle = 1. The round-robin pointer last_grant = 1, so requester 0 wins first. req0_ready and req1_ready = 1.
- reqN_ready = !fullN. It is combinational from FIFO state only and never depends on reqN_valid.
- A push occurs on a rising edge when reqN_valid && reqN_ready. The instruction is not taken when ready = 0, and the requester must hold it.
- Each FIFO keeps a count register of range 0..DEPTH. Pointers wrap modulo DEPTH.
- Push and pop on the same FIFO in the same cycle are allowed when the FIFO is not full; the count is unchanged.
- Arbitration is evaluated each cycle when issue_en = 1 and flush = 0:
  - Only one FIFO non-empty: that FIFO wins.
  - Both non-empty: the requester != last_grant wins.
  - Neither non-empty: no pop.
- On a pop, at the next edge: instr <= head entry, grant_id <= winner, instr_valid <= 1, last_grant <= winner, and issuedN increments (wrapping at 2^CNT_W).
- On a cycle with no pop (issue_en = 0 or both empty): instr_valid <= 0. instr and grant_id hold their previous values. Counters and last_grant hold.
- Latency: an instruction pushed at edge E into an empty FIFO, with issue_en = 1 and no contention, has instr_valid = 1 in the cycle after edge E+1. That is 2 cycles from push to issue.
- Throughput: 1 instruction per cycle total. Under sustained contention the requesters alternate strictly.
- Flush, at the edge: both FIFOs are emptied, instr_valid <= 0, and no pop occurs. A simultaneous push is dropped; ready is still 1 if the FIFO was not full, but the data is discarded. Counters and last_grant hold.
- idle = (count0 == 0) && (count1 == 0) && !instr_valid. It is combinational from registers.
- Reset asserted mid-operation returns everything to the reset values immediately. Queued instructions are lost.

Test Plan:
1. Reset then single push: req0 pushes 16'h1123 at edge 1 -> instr_valid = 1, instr = 16'h1123, grant_id = 0 in the cycle after edge 2; issued0 = 1; idle = 1 after edge 3.
2. Contention: preload FIFO0 with A0..A3 and FIFO1 with B0..B3 while issue_en = 0, then set issue_en = 1 -> issue order A0,B0,A1,B1,A2,B2,A3,B3 on consecutive cycles; issued0 = issued1 = 4.
3. Full/backpressure (DEPTH = 4): issue_en = 0, req1 pushes 5 times -> req1_ready = 0 after the 4th accept; the 5th is held; raising issue_en -> ready returns 1 the cycle after the first pop, and the 5th word is accepted.
4. Stall: issue_en toggled 1,0,1 with FIFO0 holding 3 entries -> instr_valid pattern 1,0,1; no entry is lost or duplicated.
5. Flush: with 3 queued in FIFO0, 2 in FIFO1 and instr_valid = 1, pulse flush -> next cycle instr_valid = 0, idle = 1, counters unchanged; a subsequent push of 16'h9F01 issues normally.
6. Counter wrap (CNT_W = 4): issue 17 instructions from req0 -> issued0 = 1.
